// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the fetch PC, issues 1-cycle-latency reads to
// instruction memory and queues returned words for decode. Optional macro: FETCH_ALIGN_CHECK_EN.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic [31:0] mem_pc,
  input  logic [31:0] mem_instruct,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  output logic        fetch_fault
);

  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_LIMIT = (CW + 1)'(QDEPTH);

  logic [31:0]   fetch_pc;
  logic [31:0]   issued_pc;
  logic [31:0]   redirect_target;
  logic          inflight;
  logic          drop;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_next;
  logic [CW-1:0] count;
  logic [CW-1:0] remaining;
  logic [CW:0]   credit_used;
  logic [31:0]   q_inst [QDEPTH];
  logic [31:0]   q_pc   [QDEPTH];
  logic [31:0]   head_inst;
  logic [31:0]   head_pc;
  logic          pop;
  logic          push;
  logic          flush;

  assign pop        = inst_valid & inst_ready;
  assign flush      = redirect_valid;
  assign push       = inflight & ~drop & ~redirect_valid;
  assign inst_valid = (count != '0);
  assign inst       = head_inst;
  assign inst_pc    = head_pc;
  assign mem_pc     = fetch_pc;

  // Credits cover queued words plus the one still in flight, so a response never hits a full queue.
  assign credit_used = {1'b0, count} + {{CW{1'b0}}, inflight} - {{CW{1'b0}}, pop};
  assign mem_req     = rst & ~redirect_valid & (credit_used < DEPTH_LIMIT);

  assign remaining = count - {{(CW-1){1'b0}}, pop};
  assign rd_next   = pop ? rd_ptr + PW'(1) : rd_ptr;

`ifdef FETCH_ALIGN_CHECK_EN
  logic fault_q;

  assign redirect_target = {redirect_pc[31:2], 2'b00};
  assign fetch_fault     = fault_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fault_q <= 1'b0;
    end else if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
      fault_q <= 1'b1;
    end
  end
`else
  assign redirect_target = redirect_pc;
  assign fetch_fault     = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc  <= RESET_PC;
      issued_pc <= RESET_PC;
      inflight  <= 1'b0;
      drop      <= 1'b0;
    end else begin
      inflight <= mem_req;
      drop     <= redirect_valid & inflight;
      if (mem_req) begin
        issued_pc <= fetch_pc;
      end
      if (redirect_valid) begin
        fetch_pc <= redirect_target;
      end else if (mem_req) begin
        fetch_pc <= fetch_pc + 32'd4;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      rd_ptr <= rd_next;
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (!push && pop) begin
        count <= count - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_inst[wr_ptr] <= mem_instruct;
      q_pc[wr_ptr]   <= issued_pc;
    end
  end

  // Registered head keeps the last delivered word visible once the queue drains.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_inst <= 32'h0;
      head_pc   <= 32'h0;
    end else if (!flush) begin
      if (remaining != '0) begin
        head_inst <= q_inst[rd_next];
        head_pc   <= q_pc[rd_next];
      end else if (push) begin
        head_inst <= mem_instruct;
        head_pc   <= issued_pc;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: scoreboard of expected delivered PCs,
// tagged-word memory model, cycle-exact checks of issue, stall, redirect and reset.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req;
  logic [31:0] mem_pc;
  logic [31:0] mem_instruct = 32'h0;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic        fetch_fault;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

`ifdef FETCH_ALIGN_CHECK_EN
  localparam logic [31:0] ALIGN_PC  = 32'h0000_0010;
  localparam logic [31:0] EXP_FAULT = 32'd1;
`else
  localparam logic [31:0] ALIGN_PC  = 32'h0000_0013;
  localparam logic [31:0] EXP_FAULT = 32'd0;
`endif

  instr_fetch_unit #(.RESET_PC(32'h0000_0000), .QDEPTH(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .mem_req        (mem_req),
    .mem_pc         (mem_pc),
    .mem_instruct   (mem_instruct),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_ready     (inst_ready),
    .fetch_fault    (fetch_fault)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] tag(input logic [31:0] pc);
    return pc ^ 32'h5A5A_A5A5;
  endfunction

  // Instruction memory: one-cycle latency, word tagged by its address
  always @(posedge clk) begin
    if (mem_req) mem_instruct <= tag(mem_pc);
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic rv, input logic [31:0] rpc, input logic rdy);
    redirect_valid = rv;
    redirect_pc    = rpc;
    inst_ready     = rdy;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every accepted word must match the oldest expected PC and its tag
  always @(negedge clk) begin
    if (rst && inst_valid && inst_ready) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_delivery", inst_pc, 32'hDEAD_BEEF);
      end else begin
        logic [31:0] exp_pc;
        exp_pc = exp_q.pop_front();
        checkOutput("deliver_pc", inst_pc, exp_pc);
        checkOutput("deliver_inst", inst, tag(exp_pc));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b1);
    repeat (2) @(posedge clk);
    #2;
    checkOutput("rst_mem_req", {31'b0, mem_req}, 32'd0);
    checkOutput("rst_mem_pc", mem_pc, 32'h0);
    checkOutput("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
    checkOutput("rst_inst", inst, 32'h0);
    checkOutput("rst_inst_pc", inst_pc, 32'h0);
    checkOutput("rst_fault", {31'b0, fetch_fault}, 32'd0);

    // Streaming from reset, then stall with two words queued
    exp_q.push_back(32'h0); exp_q.push_back(32'h4);
    exp_q.push_back(32'h8); exp_q.push_back(32'hC);
    next_cycle(); rst = 1'b1; #1;
    checkOutput("c0_mem_req", {31'b0, mem_req}, 32'd1);
    checkOutput("c0_mem_pc", mem_pc, 32'h0);
    checkOutput("c0_inst_valid", {31'b0, inst_valid}, 32'd0);
    next_cycle(); #1;
    checkOutput("c1_mem_pc", mem_pc, 32'h4);
    checkOutput("c1_inst_valid", {31'b0, inst_valid}, 32'd0);
    next_cycle(); #1;
    checkOutput("c2_mem_pc", mem_pc, 32'h8);
    checkOutput("c2_inst_valid", {31'b0, inst_valid}, 32'd1);
    next_cycle(); next_cycle(); next_cycle(); #1;
    checkOutput("c5_mem_pc", mem_pc, 32'h14);
    next_cycle(); applyStimulus(1'b0, 32'h0, 1'b0); #1;
    checkOutput("c6_mem_req", {31'b0, mem_req}, 32'd0);
    checkOutput("c6_mem_pc", mem_pc, 32'h18);
    for (int i = 7; i <= 9; i++) begin
      next_cycle(); #1;
      checkOutput("full_mem_req", {31'b0, mem_req}, 32'd0);
      checkOutput("full_mem_pc", mem_pc, 32'h18);
      checkOutput("full_inst_valid", {31'b0, inst_valid}, 32'd1);
    end

    // Asynchronous reset mid-stream takes effect before the next edge
    #1 rst = 1'b0;
    #1;
    checkOutput("arst_inst_valid", {31'b0, inst_valid}, 32'd0);
    checkOutput("arst_mem_pc", mem_pc, 32'h0);
    checkOutput("arst_mem_req", {31'b0, mem_req}, 32'd0);

    exp_q.push_back(32'h0);  exp_q.push_back(32'h4);
    exp_q.push_back(32'h8);  exp_q.push_back(32'hC);
    exp_q.push_back(32'h40); exp_q.push_back(32'h44);
    exp_q.push_back(32'h48); exp_q.push_back(32'h4C);
    exp_q.push_back(32'hFFFF_FFF8); exp_q.push_back(32'hFFFF_FFFC);
    exp_q.push_back(32'h0);  exp_q.push_back(32'h4);
    exp_q.push_back(ALIGN_PC); exp_q.push_back(ALIGN_PC + 32'd4);

    // Restart with decode stalled: exactly two words fetched
    next_cycle(); rst = 1'b1; applyStimulus(1'b0, 32'h0, 1'b0); #1;
    checkOutput("s0_mem_req", {31'b0, mem_req}, 32'd1);
    checkOutput("s0_mem_pc", mem_pc, 32'h0);
    next_cycle(); #1;
    checkOutput("s1_mem_req", {31'b0, mem_req}, 32'd1);
    checkOutput("s1_mem_pc", mem_pc, 32'h4);
    for (int i = 2; i <= 5; i++) begin
      next_cycle(); #1;
      checkOutput("stall_mem_req", {31'b0, mem_req}, 32'd0);
      checkOutput("stall_mem_pc", mem_pc, 32'h8);
      checkOutput("stall_inst_valid", {31'b0, inst_valid}, 32'd1);
    end
    next_cycle(); applyStimulus(1'b0, 32'h0, 1'b1); #1;
    checkOutput("s6_mem_req", {31'b0, mem_req}, 32'd1);
    checkOutput("s6_mem_pc", mem_pc, 32'h8);
    next_cycle(); #1;
    checkOutput("s7_mem_pc", mem_pc, 32'hC);
    next_cycle(); #1;
    checkOutput("s8_mem_pc", mem_pc, 32'h10);

    // Redirect with PC 0x10 in flight: it must never be delivered
    next_cycle(); applyStimulus(1'b1, 32'h40, 1'b1); #1;
    checkOutput("redir_mem_req", {31'b0, mem_req}, 32'd0);
    next_cycle(); applyStimulus(1'b0, 32'h0, 1'b1); #1;
    checkOutput("post_redir_inst_valid", {31'b0, inst_valid}, 32'd0);
    checkOutput("post_redir_mem_req", {31'b0, mem_req}, 32'd1);
    checkOutput("post_redir_mem_pc", mem_pc, 32'h40);
    next_cycle(); #1;
    checkOutput("s11_mem_pc", mem_pc, 32'h44);
    next_cycle(); #1;
    checkOutput("s12_inst_pc", inst_pc, 32'h40);
    next_cycle(); next_cycle();

    // Redirect near the top of the address space: PC wraps to zero
    next_cycle(); applyStimulus(1'b1, 32'hFFFF_FFF8, 1'b1);
    next_cycle(); applyStimulus(1'b0, 32'h0, 1'b1); #1;
    checkOutput("wrap_mem_pc0", mem_pc, 32'hFFFF_FFF8);
    next_cycle(); #1;
    checkOutput("wrap_mem_pc1", mem_pc, 32'hFFFF_FFFC);
    next_cycle(); #1;
    checkOutput("wrap_mem_pc2", mem_pc, 32'h0);
    next_cycle(); next_cycle();

    // Misaligned redirect target
    next_cycle(); applyStimulus(1'b1, 32'h13, 1'b1);
    next_cycle(); applyStimulus(1'b0, 32'h0, 1'b1); #1;
    checkOutput("align_mem_pc", mem_pc, ALIGN_PC);
    checkOutput("align_fault", {31'b0, fetch_fault}, EXP_FAULT);
    next_cycle(); #1;
    checkOutput("align_mem_pc_next", mem_pc, ALIGN_PC + 32'd4);
    next_cycle(); next_cycle();
    next_cycle(); applyStimulus(1'b0, 32'h0, 1'b0);
    repeat (3) next_cycle();
    #1;
    checkOutput("fault_sticky", {31'b0, fetch_fault}, EXP_FAULT);

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) next_cycle();
    checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    rst = 1'b0;
    #2;
    checkOutput("final_rst_fault", {31'b0, fetch_fault}, 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
